// File: rtl/divisor_freq_prog.sv
// -----------------------------------------------------------------------------
// divisor_freq_prog
//
// Programmable frequency divider. A free-running counter wraps each time it
// reaches the active divisor. That wrap is the "terminal event", so one output
// period is div_cur+1 enabled cycles. The output is either a one-cycle pulse
// after each terminal event, or a 50% square wave that toggles on each one.
//
// New divisors are loaded into a pending register. A pending value becomes
// active on the next terminal event, or on the next edge while counting is
// disabled. The divider never switches divisor in the middle of a period.
//
// Configuration macro:
//   DIVISOR_SQUARE_EN - when defined, mode=1 selects square output. When
//                       undefined, mode is ignored and f_out is always pulse.
//
// Ports:
//   f_in       in   divider clock; all logic on its rising edge
//   rst        in   asynchronous, active-high reset
//   en         in   count enable
//   load       in   divisor load request, sampled every cycle
//   div_in     in   divisor value captured when load=1
//   mode       in   0 = pulse output, 1 = square output (macro permitting)
//   f_out      out  registered divided output
//   load_ack   out  one-cycle pulse when a pending divisor becomes active
//   div_cur    out  currently active divisor
//   tick_count out  16-bit count of terminal events, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module divisor_freq_prog #(
    parameter int               WIDTH       = 26,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = 26'd10
) (
    input  logic             f_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             f_out,
    output logic             load_ack,
    output logic [WIDTH-1:0] div_cur,
    output logic [15:0]      tick_count
);

    logic [WIDTH-1:0] count_q,      count_d;
    logic [WIDTH-1:0] div_cur_q,    div_cur_d;
    logic [WIDTH-1:0] pend_q,       pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             f_out_q,      f_out_d;
    logic             load_ack_q,   load_ack_d;
    logic [15:0]      tick_q,       tick_d;

    logic             terminal;
    logic             apply;

`ifndef DIVISOR_SQUARE_EN
    // mode is part of the interface in every build but has no effect here.
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        terminal = en && (count_q >= div_cur_q);

        // Only a value that was already pending when this cycle began can be
        // applied. A load that arrives in the same cycle waits for the next
        // opportunity.
        apply = pend_valid_q && (terminal || !en);

        count_d = count_q;
        if (en) begin
            count_d = terminal ? '0 : count_q + WIDTH'(1);
        end

`ifdef DIVISOR_SQUARE_EN
        f_out_d = mode ? (f_out_q ^ terminal) : terminal;
`else
        f_out_d = terminal;
`endif

        div_cur_d    = apply ? pend_q : div_cur_q;
        // The pending register can be written while it is being applied.
        // apply reads pend_q, so the new value simply re-arms pending.
        pend_d       = load ? div_in : pend_q;
        pend_valid_d = load | (pend_valid_q & ~apply);
        load_ack_d   = apply;
        tick_d       = terminal ? tick_q + 16'd1 : tick_q;
    end

    // NOTE: every register, including the pending divisor, has a reset value.
    // A reset therefore also discards a load that has not been applied yet.
    always_ff @(posedge f_in or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            div_cur_q    <= DEFAULT_DIV;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            f_out_q      <= 1'b0;
            load_ack_q   <= 1'b0;
            tick_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments, so each register sees the
            // value its neighbours had before this edge.
            count_q      <= count_d;
            div_cur_q    <= div_cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            f_out_q      <= f_out_d;
            load_ack_q   <= load_ack_d;
            tick_q       <= tick_d;
        end
    end

    assign f_out      = f_out_q;
    assign load_ack   = load_ack_q;
    assign div_cur    = div_cur_q;
    assign tick_count = tick_q;

endmodule

// File: tb/tb_divisor_freq_prog.sv
// -----------------------------------------------------------------------------
// tb_divisor_freq_prog
//
// Self-checking bench for divisor_freq_prog. A behavioural model steps once per
// clock edge from the divider's rules. It tracks the period position, the
// active and pending divisors, the output and the event count. Each scenario
// task compares the DUT against the model and against fixed expectations.
// Define DIVISOR_SQUARE_EN for both bench and RTL to exercise square mode.
// -----------------------------------------------------------------------------
module tb_divisor_freq_prog;

    localparam int W = 26;

    logic          f_in = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic [W-1:0]  div_in;
    logic          mode;
    logic          f_out;
    logic          load_ack;
    logic [W-1:0]  div_cur;
    logic [15:0]   tick_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [W-1:0]  m_pos;      // cycles elapsed in the current period
    logic [W-1:0]  m_div;      // active divisor
    logic [W-1:0]  m_pend;     // pending divisor
    logic          m_pv;       // pending divisor is waiting
    logic          m_fout;
    logic          m_ack;
    logic [15:0]   m_ticks;

    divisor_freq_prog dut (
        .f_in       (f_in),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .div_in     (div_in),
        .mode       (mode),
        .f_out      (f_out),
        .load_ack   (load_ack),
        .div_cur    (div_cur),
        .tick_count (tick_count)
    );

    always #5 f_in = ~f_in;

    task automatic model_reset();
        m_pos = '0; m_div = W'(10); m_pend = '0; m_pv = 1'b0;
        m_fout = 1'b0; m_ack = 1'b0; m_ticks = '0;
    endtask

    // One enabled cycle finishes a period once div+1 cycles have elapsed.
    task automatic model_edge();
        bit period_end;
        bit take;
        period_end = en && (m_pos >= m_div);
        take       = m_pv && (period_end || !en);
`ifdef DIVISOR_SQUARE_EN
        if (mode) m_fout = period_end ? !m_fout : m_fout;
        else      m_fout = period_end;
`else
        m_fout = period_end;
`endif
        m_ack = take;
        if (en) m_pos = period_end ? '0 : m_pos + 1;
        if (period_end) m_ticks = m_ticks + 16'd1;
        if (take) m_div = m_pend;
        if (load) begin
            m_pend = div_in;
            m_pv   = 1'b1;
        end else if (take) begin
            m_pv = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge f_in);
        model_edge();
        #1;
    endtask

    // Pulse reset in the middle of a cycle. Everything is cleared before the
    // next edge arrives.
    task automatic pulse_reset();
        en = 1'b0; load = 1'b0; mode = 1'b0; div_in = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; div_in = '0;
        repeat (2) @(posedge f_in);
        #1;
        rst = 1'b0;
        model_reset();
        en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        // Asynchronous reset in mid-cycle, observed before the next edge.
        rst = 1'b1;
        #1;
        vectors++;
        if ({f_out, load_ack, div_cur, tick_count} !== {1'b0, 1'b0, W'(10), 16'd0}) begin
            miscompares++;
            $display("FAIL reset_values: got f_out=%b ack=%b div=%0d ticks=%0d, want 0 0 10 0",
                     f_out, load_ack, div_cur, tick_count);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default_period();
        int pulses = 0;
        pulse_reset();
        en = 1'b1;
        for (int i = 0; i < 33; i++) begin
            step();
            vectors++;
            if ({f_out, load_ack, div_cur, tick_count} !== {m_fout, m_ack, m_div, m_ticks}) begin
                miscompares++;
                $display("FAIL default_period cyc %0d: got %b %b %0d %0d, want %b %b %0d %0d", i,
                         f_out, load_ack, div_cur, tick_count, m_fout, m_ack, m_div, m_ticks);
            end
            if (f_out) pulses++;
        end
        vectors++;
        if (pulses !== 3 || tick_count !== 16'd3) begin
            miscompares++;
            $display("FAIL default_33_cycles: got pulses=%0d ticks=%0d, want 3 3", pulses, tick_count);
        end
    endtask

    // Shared body of the two load scenarios: run, then check the ack count,
    // the active divisor and the spacing between pulses.
    task automatic run_and_measure(input string name, input int cycles, input int want_div);
        int acks = 0;
        int last = -1;
        int gaps_bad = 0;
        int gaps = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            vectors++;
            if ({f_out, load_ack, div_cur, tick_count} !== {m_fout, m_ack, m_div, m_ticks}) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got %b %b %0d %0d, want %b %b %0d %0d", name, i,
                         f_out, load_ack, div_cur, tick_count, m_fout, m_ack, m_div, m_ticks);
            end
            if (load_ack) acks++;
            if (f_out) begin
                if (last >= 0) begin
                    gaps++;
                    if (i - last != want_div + 1) gaps_bad++;
                end
                last = i;
            end
        end
        vectors++;
        if (acks !== 1 || div_cur !== W'(want_div) || gaps < 3 || gaps_bad !== 0) begin
            miscompares++;
            $display("FAIL %s_summary: got acks=%0d div=%0d gaps=%0d bad=%0d, want 1 %0d >=3 0",
                     name, acks, div_cur, gaps, gaps_bad, want_div);
        end
    endtask

    task automatic test_load_midperiod();
        pulse_reset();
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        load = 1'b1; div_in = W'(4);
        step();
        load = 1'b0;
        run_and_measure("load_mid", 30, 4);
    endtask

    task automatic test_double_load();
        pulse_reset();
        en = 1'b1;
        repeat (2) step();
        load = 1'b1; div_in = W'(7);
        step();
        load = 1'b0;
        repeat (3) step();
        load = 1'b1; div_in = W'(3);
        step();
        load = 1'b0;
        run_and_measure("double_load", 30, 3);
    endtask

    task automatic test_square();
        int highs = 0;
        int want_highs;
        pulse_reset();
        en = 1'b1;
        load = 1'b1; div_in = W'(4);
        step();
        load = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            vectors++;
            if ({f_out, load_ack, div_cur, tick_count} !== {m_fout, m_ack, m_div, m_ticks}) begin
                miscompares++;
                $display("FAIL square cyc %0d: got %b %b %0d %0d, want %b %b %0d %0d", i,
                         f_out, load_ack, div_cur, tick_count, m_fout, m_ack, m_div, m_ticks);
            end
            if (i >= 11 && f_out) highs++;  // window covers edges 13..32
        end
`ifdef DIVISOR_SQUARE_EN
        want_highs = 10;
`else
        want_highs = 4;
`endif
        vectors++;
        if (highs !== want_highs) begin
            miscompares++;
            $display("FAIL square_duty: got highs=%0d in 20 cycles, want %0d", highs, want_highs);
        end
        mode = 1'b0;
    endtask

    task automatic test_enable_hold();
        pulse_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) step();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (f_out !== 1'b0 || tick_count !== 16'd0 || tick_count !== m_ticks) begin
                miscompares++;
                $display("FAIL enable_hold cyc %0d: got f_out=%b ticks=%0d, want 0 0", i, f_out, tick_count);
            end
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            vectors++;
            if (f_out !== (i == 5) || f_out !== m_fout) begin
                miscompares++;
                $display("FAIL enable_resume cyc %0d: got f_out=%b, want %b", i, f_out, (i == 5));
            end
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 4000; i++) begin
            en     = ($urandom_range(0, 3) != 0);
            load   = ($urandom_range(0, 7) == 0);
            div_in = W'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step();
            vectors++;
            if ({f_out, load_ack, div_cur, tick_count} !== {m_fout, m_ack, m_div, m_ticks}) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b %b %0d %0d, want %b %b %0d %0d", i,
                         f_out, load_ack, div_cur, tick_count, m_fout, m_ack, m_div, m_ticks);
            end
        end
        load = 1'b0; mode = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        int acks = 0;
        int pulses = 0;
        int budget = 0;
        pulse_reset();
        en = 1'b1;
        load = 1'b1; div_in = '0;
        step();
        load = 1'b0;
        // Divisor 0 gives one terminal event every enabled cycle.
        while (m_ticks != 16'hFFFF && budget < 70000) begin
            step();
            budget++;
        end
        vectors++;
        if (tick_count !== 16'hFFFF || div_cur !== '0) begin
            miscompares++;
            $display("FAIL climb_to_ffff: got ticks=%h div=%0d after %0d cycles, want ffff 0",
                     tick_count, div_cur, budget);
        end
        en = 1'b0; load = 1'b1; div_in = W'(5);
        step();
        en = 1'b1; load = 1'b0;
        step();
        vectors++;
        if (tick_count !== 16'h0000 || load_ack !== 1'b1 || div_cur !== W'(5) || tick_count !== m_ticks) begin
            miscompares++;
            $display("FAIL tick_wrap: got ticks=%h ack=%b div=%0d, want 0000 1 5",
                     tick_count, load_ack, div_cur);
        end
        // Leave a load pending in mid-period, then reset.
        en = 1'b0; load = 1'b1; div_in = W'(2);
        step();
        en = 1'b1; load = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({f_out, load_ack, div_cur, tick_count} !== {1'b0, 1'b0, W'(10), 16'd0}) begin
            miscompares++;
            $display("FAIL reset_pending: got %b %b %0d %0d, want 0 0 10 0",
                     f_out, load_ack, div_cur, tick_count);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 22; i++) begin
            step();
            vectors++;
            if ({f_out, load_ack, div_cur, tick_count} !== {m_fout, m_ack, m_div, m_ticks}) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: got %b %b %0d %0d, want %b %b %0d %0d", i,
                         f_out, load_ack, div_cur, tick_count, m_fout, m_ack, m_div, m_ticks);
            end
            if (load_ack) acks++;
            if (f_out) pulses++;
        end
        vectors++;
        if (acks !== 0 || pulses !== 2) begin
            miscompares++;
            $display("FAIL pending_discarded: got acks=%0d pulses=%0d, want 0 2", acks, pulses);
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_load_midperiod();
        test_double_load();
        test_square();
        test_enable_hold();
        test_random();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
